// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver (LSB first, idle high) feeding a small receive FIFO.
//   The serial input is brought into the clk domain through a two-flop
//   synchronizer. Bytes with a valid stop bit are pushed into the FIFO.
//   Bad stop bits and bytes lost to a full FIFO raise sticky error flags.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (even, >= 4)
//   FIFO_DEPTH   : receive FIFO entries (power of two, >= 2)
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   rx         : asynchronous serial input line
//   rd_en      : pop the FIFO head (ignored while empty)
//   err_clr    : clear frame_err and overrun (a same-cycle set wins)
//   rd_data    : FIFO head byte, valid while rx_valid=1
//   rx_valid   : FIFO non-empty
//   fifo_full  : FIFO holds FIFO_DEPTH bytes
//   frame_err  : sticky, a stop bit was sampled low
//   overrun    : sticky, a byte completed while the FIFO was full
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push;
    logic          ferr_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end

            // Half a bit in: re-check the start bit so that short
            // glitches are rejected and later samples land mid-bit.
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end

            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxs;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            // shreg_q is complete here: bit 7 was written on DATA exit.
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end
            end

            // A low line after a framing error is not a new start bit.
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO: pointers carry one extra wrap bit for full/empty
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        do_pop;
    logic        do_push;
    logic        ovr_set;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot the same-cycle push needs, so a full FIFO
    // still accepts the byte when it is being read at the same time.
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= shreg_q;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_data   = mem[rd_ptr[AW-1:0]];
    assign rx_valid  = !empty;
    assign fifo_full = full;

    // ------------------------------------------------------------------
    // Sticky error flags (set wins over clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
//   Stimulus pushes every byte it expects to be stored into exp_q; the
//   monitor drives rd_en and compares each popped head byte in order.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       fifo_full;
    logic       frame_err;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         drain   = 1'b0;
    bit         pop_req = 1'b0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rd_en    (rd_en),
        .err_clr  (err_clr),
        .rd_data  (rd_data),
        .rx_valid (rx_valid),
        .fifo_full(fifo_full),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %02h required %02h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %b required %b", name, act, req);
        end
    endtask

    // Monitor: owns rd_en; every pop of a valid head is scored.
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = drain || pop_req;
            if (rd_en && !reset && rx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: actual %02h required none", rd_data);
                end else begin
                    check8("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    // One 8N1 frame. Start bit is driven on negedge N0; the stop sample
    // (push edge) is then posedge 155. pop_on_push raises rd_en for that
    // edge only; chk_lat checks rx_valid just before and after it.
    task automatic send(input logic [7:0] b, input logic stop_bit,
                        input bit pop_on_push, input bit chk_lat);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB / 2 + 1) @(negedge clk);
        @(posedge clk);
        #1;
        if (pop_on_push) pop_req = 1'b1;
        if (chk_lat) check1("valid_before_stop", rx_valid, 1'b0);
        @(posedge clk);
        #1;
        pop_req = 1'b0;
        if (chk_lat) check1("valid_after_stop", rx_valid, 1'b1);
        repeat (CPB / 2 - 2) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check1({tag, "_rx_valid"},  rx_valid,  1'b0);
        check1({tag, "_fifo_full"}, fifo_full, 1'b0);
        check1({tag, "_frame_err"}, frame_err, 1'b0);
        check1({tag, "_overrun"},   overrun,   1'b0);
        check8({tag, "_rd_data"},   rd_data,   8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        err_clr = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Single frame, read as soon as it appears
        drain = 1'b1;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check1("a5_drained", rx_valid, 1'b0);
        check8("a5_q_empty", 8'(exp_q.size()), 8'd0);

        // Short low glitch must be rejected
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check1("glitch_rx_valid", rx_valid, 1'b0);
        check1("glitch_frame_err", frame_err, 1'b0);
        check1("glitch_overrun", overrun, 1'b0);

        // Framing error: byte discarded, sticky flag until err_clr
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        check1("ferr_set", frame_err, 1'b1);
        check1("ferr_rx_valid", rx_valid, 1'b0);
        pulse_err_clr();
        check1("ferr_clr", frame_err, 1'b0);

        // Overfill: fifth byte dropped with overrun
        drain = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (b <= DEPTH) exp_q.push_back(8'(b));
            send(8'(b), 1'b1, 1'b0, 1'b0);
        end
        check1("ovf_full", fifo_full, 1'b1);
        check1("ovf_overrun", overrun, 1'b1);
        check1("ovf_rx_valid", rx_valid, 1'b1);
        drain = 1'b1;
        repeat (8) @(negedge clk);
        drain = 1'b0;
        check1("ovf_drained", rx_valid, 1'b0);
        check1("ovf_not_full", fifo_full, 1'b0);
        check8("ovf_q_empty", 8'(exp_q.size()), 8'd0);
        pulse_err_clr();
        check1("ovr_clr", overrun, 1'b0);

        // Full FIFO with push and pop on the same edge
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send(8'(b), 1'b1, 1'b0, 1'b0);
        end
        check1("refill_full", fifo_full, 1'b1);
        exp_q.push_back(8'h77);
        send(8'h77, 1'b1, 1'b1, 1'b0);
        check1("pushpop_overrun", overrun, 1'b0);
        check1("pushpop_full", fifo_full, 1'b1);
        drain = 1'b1;
        repeat (8) @(negedge clk);
        drain = 1'b0;
        check1("pushpop_drained", rx_valid, 1'b0);
        check8("pushpop_q_empty", 8'(exp_q.size()), 8'd0);

        // Reset during data bit 3, then a clean frame
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check1("midrst_no_push", rx_valid, 1'b0);
        drain = 1'b1;
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        drain = 1'b0;
        check8("5a_q_empty", 8'(exp_q.size()), 8'd0);
        check1("5a_rx_valid", rx_valid, 1'b0);
        check1("5a_frame_err", frame_err, 1'b0);
        check1("5a_overrun", overrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
